pio_edge_poller: RTL and testbench
==================================

# pio_edge_poller

Avalon-MM initiator that autonomously services an edge-capturing PIO input slave, such as the 18-bit toggle-switch PIO. On a fixed interval it reads the slave's edge-capture register at address 3. When the captured value is non-zero, it clears the register by writing to the same address and pushes the value into a small first-word-fall-through event FIFO for downstream logic. This removes interrupt and polling load from the Nios cores in the multicore image-processing system.

## Interface
- WIDTH, 18: captured bit count; uses m_readdata[WIDTH-1:0].
- POLL_DIV, 1000: idle cycles between polls; must be ≥ 1.
- FIFO_DEPTH, 8: event FIFO entries; must be a power of 2 and ≥ 2.
- EDGE_ADDR, 3: slave word address of the edge-capture register.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  polling enable; sampled in IDLE only.
- m_address  out  2  slave word address.
- m_chipselect  out  1  slave select.
- m_write_n  out  1  active-low write strobe.
- m_writedata  out  32  write data; always 0.
- m_readdata  in  32  slave read data; registered by the slave, fixed 1-cycle latency, no waitrequest.
- ev_valid  out  1  FIFO non-empty.
- ev_data  out  WIDTH  FIFO head; don't-care when ev_valid=0.
- ev_ready  in  1  pop request; a pop occurs when ev_valid && ev_ready.
- overflow  out  1  sticky flag: a non-zero sample was dropped.
- clr_overflow  in  1  clears overflow.
- busy  out  1  state != IDLE.

## Operation
- The FSM has four states: IDLE, READ, RDATA, CLEAR. Bus outputs are decoded from the state register only.
- IDLE: address=0, chipselect=0, write_n=1.
  - A poll counter (width clog2(POLL_DIV)+1) increments each cycle enable=1 and holds at 0 while enable=0.
  - When counter==POLL_DIV-1 and enable=1, the counter goes to 0 and the FSM goes to READ.
- READ: address=EDGE_ADDR, chipselect=1, write_n=1. Goes unconditionally to RDATA.
- RDATA: address=EDGE_ADDR, chipselect=0. Latches sample=m_readdata[WIDTH-1:0] at the end of the cycle.
  - Sample ≠ 0 → CLEAR.
  - Sample = 0 → IDLE, with no write and no push.
- CLEAR: address=EDGE_ADDR, chipselect=1, write_n=0, writedata=0. Pushes sample into the FIFO in this cycle, then goes to IDLE.
- FIFO:
  - Occupancy counter width clog2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle (count unchanged).
  - A refused push drops the sample and sets overflow. The clear write is still issued.
  - Simultaneous push and pop on an empty FIFO: push only (ev_valid is 0, so no pop).
- overflow: set has priority over clr_overflow in the same cycle.
- enable falling mid-transaction: the transaction completes and the FSM then holds in IDLE.
- Loss window: the slave's clear is all-bits and takes priority. Slave capture bits newly set on the clock edges ending READ, RDATA and CLEAR are not in the sample and are cleared, so they are lost. This is accepted behaviour.

## Timing
- Reset values: state IDLE, m_address 0, m_chipselect 0, m_write_n 1, m_writedata 0, ev_valid 0, overflow 0, busy 0, FIFO empty, poll counter 0.
- With enable=1 from reset release, the first READ cycle is cycle POLL_DIV (cycles counted from 0).
- Poll period: POLL_DIV+2 cycles when the sample is 0; POLL_DIV+3 when non-zero.
- Push to ev_valid: ev_valid rises in the cycle after CLEAR.
- ev_data is the FIFO head combinationally (FWFT).
- Asserting reset_n in any state returns all outputs to reset values immediately. FIFO contents and overflow are discarded.

## Test plan
- Reset check: all outputs at reset values; no chipselect for the first POLL_DIV cycles with enable=1 (POLL_DIV=16).
- Single edge: slave model bit 5 goes 1→0 → one READ/RDATA/CLEAR sequence with write at address 3, data 0; ev_data=18'h00020 with ev_valid; slave capture reads 0 afterwards. The next poll performs no write.
- Quiet input: no edges → only READ/RDATA pairs every 18 cycles, ev_valid stays 0, m_write_n stays 1.
- FIFO full: ev_ready=0, FIFO_DEPTH=8, nine non-zero polls → 8 entries, overflow=1, ninth clear still issued. clr_overflow pulsed in the same cycle as a new drop → overflow stays 1; pulsed alone → overflow goes 0.
- Full with same-cycle pop: ev_ready=1 during a CLEAR at full → count stays 8; popped order is first-in first-out; the new sample appears last.
- Mid-operation reset: reset_n driven low during CLEAR → m_chipselect=0 and m_write_n=1 immediately. After release: ev_valid=0 and the first READ follows POLL_DIV cycles later.

Source files
------------

// File: rtl/pio_edge_poller.sv
// pio_edge_poller
// Avalon-MM initiator that periodically reads an edge-capturing PIO's
// edge-capture register, clears it when non-zero, and queues the captured
// value in a small first-word-fall-through event FIFO.
module pio_edge_poller #(
  parameter int WIDTH      = 18,
  parameter int POLL_DIV   = 1000,
  parameter int FIFO_DEPTH = 8,
  parameter int EDGE_ADDR  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [1:0]       m_address,
  output logic             m_chipselect,
  output logic             m_write_n,
  output logic [31:0]      m_writedata,
  input  logic [31:0]      m_readdata,
  output logic             ev_valid,
  output logic [WIDTH-1:0] ev_data,
  input  logic             ev_ready,
  output logic             overflow,
  input  logic             clr_overflow,
  output logic             busy
);

  localparam int CNT_W = $clog2(POLL_DIV) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_DIV - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
  localparam logic [1:0]       ADDR_EDGE = 2'(EDGE_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_RDATA = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_poll_cnt;
  logic [WIDTH-1:0]   r_sample;
  logic [WIDTH-1:0]   w_rd_sample;

  logic [WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [OCC_W-1:0]   r_count;
  logic               r_overflow;

  logic               w_poll_due;
  logic               w_push;
  logic               w_pop;
  logic               w_push_ok;

  // Only the captured field of the read data matters; upper bits are ignored.
  assign w_rd_sample = m_readdata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_unused_hi
    logic w_unused_readdata;
    assign w_unused_readdata = ^m_readdata[31:WIDTH];
  end

  assign w_poll_due = enable && (r_poll_cnt == POLL_LAST);

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: poll when the interval expires, clear only non-zero samples.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_poll_due) w_state_next = ST_READ;
      ST_READ:  w_state_next = ST_RDATA;
      ST_RDATA: w_state_next = (w_rd_sample != '0) ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Bus strobes decoded from the state register only (glitch-free, no input paths).
  always_comb begin
    m_address    = 2'd0;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    case (r_state)
      ST_READ: begin
        m_address    = ADDR_EDGE;
        m_chipselect = 1'b1;
      end
      ST_RDATA: begin
        m_address    = ADDR_EDGE;
      end
      ST_CLEAR: begin
        m_address    = ADDR_EDGE;
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
      end
      default: begin
        m_address    = 2'd0;
      end
    endcase
  end

  assign m_writedata = 32'd0;
  assign busy        = (r_state != ST_IDLE);

  // Poll interval counter: runs only in IDLE while enabled, restarts on each poll.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poll_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (!enable || (r_poll_cnt == POLL_LAST)) begin
        r_poll_cnt <= '0;
      end else begin
        r_poll_cnt <= r_poll_cnt + CNT_W'(1);
      end
    end
  end

  // Capture the slave's read data in the cycle it is valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample <= '0;
    end else if (r_state == ST_RDATA) begin
      r_sample <= w_rd_sample;
    end
  end

  // FIFO handshake: a pop frees a slot in the same cycle, so a full FIFO
  // still accepts a push when the consumer is draining.
  assign w_push    = (r_state == ST_CLEAR);
  assign w_pop     = ev_valid && ev_ready;
  assign w_push_ok = w_push && ((r_count < OCC_FULL) || w_pop);

  // Event storage; contents are meaningless outside the occupied range.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= r_sample;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)     r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky drop flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_push && !w_push_ok) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign ev_valid = (r_count != '0);
  assign ev_data  = r_mem[r_rptr];
  assign overflow = r_overflow;

endmodule

// File: tb/tb_pio_edge_poller.sv
// Bench for pio_edge_poller with a behavioural edge-capture PIO slave
// and a queue of expected events.
module tb_pio_edge_poller;

  localparam int W  = 18;
  localparam int PD = 16;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          ev_ready = 1'b0;
  logic          clr_overflow = 1'b0;
  logic [1:0]    m_address;
  logic          m_chipselect;
  logic          m_write_n;
  logic [31:0]   m_writedata;
  logic [31:0]   m_readdata;
  logic          ev_valid;
  logic [W-1:0]  ev_data;
  logic          overflow;
  logic          busy;

  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;

  logic [W-1:0]  sw = '1;
  logic [W-1:0]  sw_prev;
  logic [31:0]   cap;
  logic [W-1:0]  exp_q [$];

  pio_edge_poller #(
    .WIDTH(W), .POLL_DIV(PD), .FIFO_DEPTH(FD), .EDGE_ADDR(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write_n(m_write_n), .m_writedata(m_writedata),
    .m_readdata(m_readdata),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
    .overflow(overflow), .clr_overflow(clr_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge-capture PIO slave: falling edges captured, clear write wins.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap        <= 32'd0;
      sw_prev    <= sw;
      m_readdata <= 32'd0;
    end else begin
      sw_prev <= sw;
      if (m_chipselect && !m_write_n && m_address == 2'd3)
        cap <= 32'd0;
      else
        cap <= cap | {14'd0, sw_prev & ~sw};
      if (m_chipselect && m_write_n && m_address == 2'd3)
        m_readdata <= cap;
      else
        m_readdata <= 32'd0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded, n_fail=%0d", $time, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_chipselect === 1'b1 && m_write_n === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Create falling edges on the bits of m while idle; return at the CLEAR-cycle negedge.
  task automatic run_edge_poll(input logic [W-1:0] m, output bit ok);
    bit a, b;
    wait_idle(a);
    sw = ~m;
    $display("poll: edge mask %05h at cycle %0d", m, cyc);
    wait_read(b);
    @(negedge clk);
    @(negedge clk);
    ok = a & b;
  endtask

  task automatic test_reset;
    int early;
    reset_n = 1'b0;
    enable  = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (m_address !== 2'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", m_address); end
    n_checks++; if (m_chipselect !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b expected 0", m_chipselect); end
    n_checks++; if (m_write_n !== 1'b1) begin n_fail++; $display("FAIL reset_wn: got %b expected 1", m_write_n); end
    n_checks++; if (m_writedata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", m_writedata); end
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid: got %b expected 0", ev_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    early = 0;
    for (int k = 0; k < PD; k++) begin
      if (m_chipselect !== 1'b0) early++;
      @(negedge clk);
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL reset_quiet: got %0d early selects expected 0", early); end
    n_checks++; if (m_chipselect !== 1'b1 || m_write_n !== 1'b1) begin n_fail++; $display("FAIL first_read: got cs=%b wn=%b expected cs=1 wn=1", m_chipselect, m_write_n); end
    n_checks++; if (m_address !== 2'd3) begin n_fail++; $display("FAIL first_read_addr: got %0d expected 3", m_address); end
  endtask

  task automatic test_single_edge;
    bit ok;
    logic [W-1:0] exp;
    int writes;
    exp_q.push_back(18'h00020);
    run_edge_poll(18'h00020, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got no poll expected one"); end
    n_checks++; if (m_chipselect !== 1'b1 || m_write_n !== 1'b0) begin n_fail++; $display("FAIL single_clear: got cs=%b wn=%b expected cs=1 wn=0", m_chipselect, m_write_n); end
    n_checks++; if (m_address !== 2'd3 || m_writedata !== 32'd0) begin n_fail++; $display("FAIL single_clear_aw: got addr=%0d data=%h expected 3/0", m_address, m_writedata); end
    sw = '1;
    @(negedge clk);
    n_checks++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", ev_valid); end
    exp = exp_q.pop_front();
    n_checks++; if (ev_data !== exp) begin n_fail++; $display("FAIL single_data: got %05h expected %05h", ev_data, exp); end
    n_checks++; if (cap !== 32'd0) begin n_fail++; $display("FAIL single_cap_cleared: got %h expected 0", cap); end
    $display("pop: data %05h at cycle %0d", ev_data, cyc);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b expected 0", ev_valid); end
    wait_read(ok);
    writes = 0;
    repeat (3) begin
      @(negedge clk);
      if (m_write_n === 1'b0) writes++;
    end
    n_checks++; if (!ok || writes != 0) begin n_fail++; $display("FAIL single_next_poll: got ok=%b writes=%0d expected ok=1 writes=0", ok, writes); end
  endtask

  task automatic test_quiet;
    bit ok;
    int t_prev, nw, nv, nreads;
    wait_read(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL quiet_timeout: got no read expected one"); end
    t_prev = cyc; nw = 0; nv = 0; nreads = 0;
    for (int i = 0; i < 3 * (PD + 2); i++) begin
      @(negedge clk);
      if (m_write_n !== 1'b1) nw++;
      if (ev_valid !== 1'b0) nv++;
      if (m_chipselect === 1'b1 && m_write_n === 1'b1) begin
        nreads++;
        $display("poll: quiet read at cycle %0d", cyc);
        n_checks++; if (cyc - t_prev != PD + 2) begin n_fail++; $display("FAIL quiet_period: got %0d expected %0d", cyc - t_prev, PD + 2); end
        t_prev = cyc;
      end
    end
    n_checks++; if (nreads != 3) begin n_fail++; $display("FAIL quiet_reads: got %0d expected 3", nreads); end
    n_checks++; if (nw != 0 || nv != 0) begin n_fail++; $display("FAIL quiet_idle: got writes=%0d valid=%0d expected 0/0", nw, nv); end
  endtask

  task automatic test_fifo_full;
    bit ok;
    logic [W-1:0] m;
    ev_ready = 1'b0;
    for (int i = 0; i < FD + 1; i++) begin
      m = {9'(i + 1), 9'h1A5 ^ 9'(i)};
      run_edge_poll(m, ok);
      n_checks++; if (!ok || m_write_n !== 1'b0) begin n_fail++; $display("FAIL full_clear_%0d: got ok=%b wn=%b expected 1/0", i, ok, m_write_n); end
      if (i == FD) begin
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf_yet: got %b expected 0", overflow); end
      end else begin
        exp_q.push_back(m);
      end
      sw = '1;
    end
    @(negedge clk);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_overflow: got %b expected 1", overflow); end
    n_checks++; if (ev_valid !== 1'b1 || ev_data !== exp_q[0]) begin n_fail++; $display("FAIL full_head: got v=%b d=%05h expected 1/%05h", ev_valid, ev_data, exp_q[0]); end
    // Clear request coinciding with another drop: the drop wins.
    run_edge_poll(18'h2AAAA, ok);
    clr_overflow = 1'b1;
    sw = '1;
    @(negedge clk);
    clr_overflow = 1'b0;
    n_checks++; if (!ok || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got ok=%b ovf=%b expected 1/1", ok, overflow); end
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_full_pop;
    bit ok;
    logic [W-1:0] exp;
    logic [W-1:0] m_new;
    m_new = 18'h15555;
    run_edge_poll(m_new, ok);
    n_checks++; if (!ok || m_write_n !== 1'b0) begin n_fail++; $display("FAIL fullpop_clear: got ok=%b wn=%b expected 1/0", ok, m_write_n); end
    exp = exp_q.pop_front();
    n_checks++; if (ev_valid !== 1'b1 || ev_data !== exp) begin n_fail++; $display("FAIL fullpop_head: got v=%b d=%05h expected 1/%05h", ev_valid, ev_data, exp); end
    $display("pop: data %05h at cycle %0d", ev_data, cyc);
    exp_q.push_back(m_new);
    ev_ready = 1'b1;
    sw = '1;
    @(negedge clk);
    ev_ready = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_no_ovf: got %b expected 0", overflow); end
    ev_ready = 1'b1;
    for (int i = 0; i < FD; i++) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL fullpop_queue_%0d: got empty expected entry", i);
        break;
      end
      exp = exp_q.pop_front();
      n_checks++; if (ev_valid !== 1'b1 || ev_data !== exp) begin n_fail++; $display("FAIL fullpop_order_%0d: got v=%b d=%05h expected 1/%05h", i, ev_valid, ev_data, exp); end
      $display("pop: data %05h at cycle %0d", ev_data, cyc);
      @(negedge clk);
    end
    ev_ready = 1'b0;
    n_checks++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_drained: got %b expected 0", ev_valid); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int early;
    run_edge_poll(18'h00F0F, ok);
    sw = '1;
    exp_q.push_back(18'h00F0F);
    @(negedge clk);
    n_checks++; if (!ok || ev_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_preload: got ok=%b v=%b expected 1/1", ok, ev_valid); end
    run_edge_poll(18'h30001, ok);
    reset_n = 1'b0;
    #1;
    n_checks++; if (m_chipselect !== 1'b0 || m_write_n !== 1'b1) begin n_fail++; $display("FAIL midrst_bus: got cs=%b wn=%b expected 0/1", m_chipselect, m_write_n); end
    n_checks++; if (busy !== 1'b0 || ev_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got busy=%b v=%b expected 0/0", busy, ev_valid); end
    exp_q.delete();
    sw = '1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    early = 0;
    for (int k = 0; k < PD; k++) begin
      if (m_chipselect !== 1'b0 || ev_valid !== 1'b0) early++;
      @(negedge clk);
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d bad cycles expected 0", early); end
    n_checks++; if (m_chipselect !== 1'b1 || m_write_n !== 1'b1) begin n_fail++; $display("FAIL midrst_first_read: got cs=%b wn=%b expected 1/1", m_chipselect, m_write_n); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_quiet();
    test_fifo_full();
    test_full_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
